div_tick_sync: RTL and testbench

- Sits directly downstream of the ripple frequency divider. Consumes its four divided outputs (÷2, ÷4, ÷8, ÷16), which are asynchronous to the system clock.
- Synchronises all four taps into the clk domain and selects one tap via a request/acknowledge handshake.
- Emits a single-cycle tick on each rising edge of the selected tap and keeps a wrapping tick count.
- Tap switching is glitch-free: no spurious tick is ever produced by a change of selection.

---
 rtl/div_tick_sync.sv | 123 ++++++++++++
 tb/tb_div_tick_sync.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_tick_sync.sv
// Synchronises the four ripple-divider taps into clk, selects one tap by request/ack,
// and emits a counted single-cycle tick on each rising edge of the selected tap.
module div_tick_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       taps,
    input  logic [1:0]       sel,
    input  logic             sel_req,
    output logic             sel_ack,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             cnt_wrap,
    output logic             active
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic             prev_q, prev_d;
    logic             sel_ack_q, sel_ack_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             cnt_wrap_q, cnt_wrap_d;
    logic             active_q, active_d;

    logic sync_t;
    logic rise;

    assign sync_t = sync_q[SYNC_STAGES-1][cur_sel_q];
    assign rise   = sync_t & ~prev_q;

    // Every tap is synchronised all the time so a newly selected tap is already settled.
    always_comb begin
        sync_d[0] = taps;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        prev_d     = sync_t;
        sel_ack_d  = 1'b0;
        tick_d     = 1'b0;
        tick_cnt_d = tick_cnt_q;
        cnt_wrap_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (sel_req) begin
                    cur_sel_d = sel;
                    state_d   = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                tick_cnt_d = '0;
                // Enter RUN only from a low tap so the first tick is a genuine rising edge.
                if (!sync_t) begin
                    state_d   = ST_RUN;
                    sel_ack_d = 1'b1;
                    prev_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (rise) begin
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    cnt_wrap_d = (tick_cnt_q == '1);
                end
                if (sel_req) begin
                    cur_sel_d = sel;
                    state_d   = ST_SWITCH;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
            end
        endcase

        active_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            cur_sel_q  <= '0;
            prev_q     <= 1'b0;
            sel_ack_q  <= 1'b0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
            cnt_wrap_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            prev_q     <= prev_d;
            sel_ack_q  <= sel_ack_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
            cnt_wrap_q <= cnt_wrap_d;
            active_q   <= active_d;
        end
    end

    assign sel_ack  = sel_ack_q;
    assign tick     = tick_q;
    assign tick_cnt = tick_cnt_q;
    assign cnt_wrap = cnt_wrap_q;
    assign active   = active_q;

endmodule

// File: tb/tb_div_tick_sync.sv
// Bench for div_tick_sync: directed scenarios plus randomized divider/select traffic,
// all checked against a delay-line reference model of the tap selection behaviour.
module tb_div_tick_sync;

    localparam int SYNC = 2;
    localparam int CW   = 4;

    logic          clk;
    logic          reset;
    logic [3:0]    taps;
    logic [1:0]    sel;
    logic          sel_req;
    logic          sel_ack;
    logic          tick;
    logic [CW-1:0] tick_cnt;
    logic          cnt_wrap;
    logic          active;

    int checks;
    int errors;
    int unsigned cyc;

    div_tick_sync #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .taps     (taps),
        .sel      (sel),
        .sel_req  (sel_req),
        .sel_ack  (sel_ack),
        .tick     (tick),
        .tick_cnt (tick_cnt),
        .cnt_wrap (cnt_wrap),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural ripple divider: taps is a binary count advancing every div_period clocks.
    bit         div_en;
    int         div_period;
    int         div_cnt;
    logic [3:0] div_val;
    always begin
        @(negedge clk);
        if (div_en) begin
            div_cnt++;
            if (div_cnt >= div_period) begin
                div_cnt = 0;
                div_val = div_val + 4'd1;
                taps    = div_val;
            end
        end
    end

    // Reference model: the selected tap is seen SYNC edges late; states 0=idle 1=switch 2=run.
    int            m_st;
    logic [1:0]    m_cur;
    logic [3:0]    hist [0:SYNC];
    logic          m_ack, m_tick, m_wrap, m_active, m_now, m_old;
    logic [CW-1:0] m_cnt;
    always begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_st = 0; m_cur = 2'd0; m_ack = 1'b0; m_tick = 1'b0;
            m_wrap = 1'b0; m_active = 1'b0; m_cnt = '0;
            for (int j = 0; j <= SYNC; j++) hist[j] = 4'd0;
        end else begin
            m_now = hist[SYNC-1][m_cur];
            m_old = hist[SYNC][m_cur];
            for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = taps;
            m_ack = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
            case (m_st)
                0: begin
                    m_cnt = '0;
                    if (sel_req) begin m_cur = sel; m_st = 1; end
                end
                1: begin
                    m_cnt = '0;
                    if (!m_now) begin m_st = 2; m_ack = 1'b1; end
                end
                default: begin
                    if (m_now && !m_old) begin
                        m_tick = 1'b1;
                        m_wrap = (m_cnt == {CW{1'b1}});
                        m_cnt  = m_cnt + 1'b1;
                    end
                    if (sel_req) begin m_cur = sel; m_st = 1; end
                end
            endcase
            m_active = (m_st == 2);
        end
    end

    logic [CW+3:0] dut_vec, mdl_vec;
    assign dut_vec = {sel_ack, tick, cnt_wrap, active, tick_cnt};
    assign mdl_vec = {m_ack, m_tick, m_wrap, m_active, m_cnt};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        div_val = 4'd0; div_cnt = 0; div_period = 10; div_en = 1;
        reset = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (dut_vec !== '0) begin
                errors++;
                $display("FAIL reset_hold dut=%h want=0", dut_vec);
            end
        end
        reset = 1'b1;
        repeat (60) begin
            step();
            checks++;
            if (dut_vec !== '0) begin
                errors++;
                $display("FAIL reset_idle dut=%h want=0", dut_vec);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL reset_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_basic_select();
        bit found;
        int n;
        int unsigned stamp [0:4];
        sel = 2'd1; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL basic_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
            if (sel_ack) found = 1; else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL basic_ack_timeout got=0 want=1");
        end
        n = 0;
        for (int i = 0; i < 400 && n < 5; i++) begin
            step();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL basic_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
            if (tick) begin
                stamp[n] = cyc;
                n++;
            end
        end
        checks++;
        if (n != 5 || tick_cnt !== 4'd5) begin
            errors++;
            $display("FAIL basic_count ticks=%0d cnt=%0d want=5/5", n, tick_cnt);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (i < n && (stamp[i] - stamp[i-1] < 39 || stamp[i] - stamp[i-1] > 41)) begin
                errors++;
                $display("FAIL basic_period got=%0d want=40", stamp[i] - stamp[i-1]);
            end
        end
    endtask

    task automatic test_latency();
        bit found;
        div_en = 0;
        taps = 4'd0;
        repeat (4) step();
        sel = 2'd0; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (sel_ack) found = 1; else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL latency_ack_timeout got=0 want=1");
        end
        repeat (3) step();
        taps = 4'b0001;
        for (int j = 1; j <= 5; j++) begin
            step();
            checks++;
            if (tick !== (j == SYNC + 1)) begin
                errors++;
                $display("FAIL latency_tick edge=%0d got=%b want=%b", j, tick, (j == SYNC + 1));
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL latency_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (tick_cnt !== 4'd1) begin
            errors++;
            $display("FAIL latency_cnt got=%0d want=1", tick_cnt);
        end
        taps = 4'd0;
        repeat (4) step();
    endtask

    task automatic test_glitch_free();
        bit found;
        taps = 4'b1000;
        repeat (4) step();
        sel = 2'd3; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) taps[0] = ~taps[0];
            step();
            checks++;
            if (tick !== 1'b0 || sel_ack !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL glitch_hold tick=%b ack=%b active=%b want=000", tick, sel_ack, active);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL glitch_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
        end
        taps[3] = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (sel_ack) found = 1;
        end
        checks++;
        if (!found || tick_cnt !== 4'd0) begin
            errors++;
            $display("FAIL glitch_ack ack=%b cnt=%0d want=1/0", found, tick_cnt);
        end
        repeat (5) begin
            step();
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL glitch_quiet tick=%b want=0", tick);
            end
        end
        taps[3] = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            checks++;
            if (tick !== (j == SYNC + 1)) begin
                errors++;
                $display("FAIL glitch_first_tick edge=%0d got=%b want=%b", j, tick, (j == SYNC + 1));
            end
        end
        checks++;
        if (tick_cnt !== 4'd1) begin
            errors++;
            $display("FAIL glitch_cnt got=%0d want=1", tick_cnt);
        end
    endtask

    task automatic test_wrap();
        bit found;
        int n_ticks, n_wraps;
        taps = 4'd0;
        repeat (4) step();
        sel = 2'd0; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (sel_ack) found = 1; else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_ack_timeout got=0 want=1");
        end
        n_ticks = 0; n_wraps = 0;
        for (int p = 0; p < 16 * 6 + 4; p++) begin
            if (p < 16 * 6) taps[0] = ((p % 6) < 3);
            step();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL wrap_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
            if (cnt_wrap) n_wraps++;
            if (tick) begin
                n_ticks++;
                checks++;
                if (tick_cnt !== CW'(n_ticks % (1 << CW)) || cnt_wrap !== (n_ticks == 16)) begin
                    errors++;
                    $display("FAIL wrap_step tick#%0d cnt=%0d wrap=%b want=%0d/%b",
                             n_ticks, tick_cnt, cnt_wrap, n_ticks % (1 << CW), (n_ticks == 16));
                end
            end
        end
        checks++;
        if (n_ticks != 16 || n_wraps != 1) begin
            errors++;
            $display("FAIL wrap_totals ticks=%0d wraps=%0d want=16/1", n_ticks, n_wraps);
        end
    endtask

    task automatic test_reset_mid_switch();
        bit found;
        taps = 4'b0100;
        repeat (3) step();
        sel = 2'd2; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        repeat (3) step();
        checks++;
        if (active !== 1'b0 || sel_ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_switch active=%b ack=%b want=0/0", active, sel_ack);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL midrst_async dut=%h want=0", dut_vec);
        end
        @(negedge clk);
        step();
        reset = 1'b1;
        div_val = taps; div_cnt = 0; div_period = 5; div_en = 1;
        repeat (60) begin
            step();
            checks++;
            if (tick !== 1'b0 || active !== 1'b0 || sel_ack !== 1'b0) begin
                errors++;
                $display("FAIL midrst_idle tick=%b active=%b ack=%b want=000", tick, active, sel_ack);
            end
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL midrst_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
        end
        sel = 2'd0; sel_req = 1'b1;
        step();
        sel_req = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (sel_ack) found = 1; else step();
        end
        checks++;
        if (!found || active !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reselect ack=%b active=%b want=1/1", found, active);
        end
        // Reset while ack/active are high must clear them without waiting for clk.
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL midrst_async_ack dut=%h want=0", dut_vec);
        end
        @(negedge clk);
        step();
        reset = 1'b1;
    endtask

    task automatic test_random();
        div_val = taps; div_cnt = 0; div_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) div_period = int'($urandom_range(3, 12));
            sel     = 2'($urandom_range(0, 3));
            sel_req = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 799) != 0);
            step();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++;
                $display("FAIL random_model t=%0t dut=%h model=%h", $time, dut_vec, mdl_vec);
            end
        end
        reset = 1'b1;
        sel_req = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; taps = 4'd0; sel = 2'd0; sel_req = 1'b0;
        div_en = 0; div_period = 10; div_cnt = 0; div_val = 4'd0;
        @(negedge clk);
        test_reset();
        test_basic_select();
        test_latency();
        test_glitch_free();
        test_wrap();
        test_reset_mid_switch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout t=%0t want=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
